// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-front-end program-counter generator.
//   pc_state_e : controller states (BOOT, RUN, HOLD)
//   STALL_PC   : index of the PC-stage stall on the pipeline stall bus
//   DEF_ADDR_W : default PC width shared with the fetch stage
//   DEF_STEP   : default bytes per sequential fetch shared with the fetch stage
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  localparam int unsigned STALL_PC   = 0;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_STEP   = 4;

endpackage : pc_pkg

// File: rtl/pc_gen.sv
// Program-counter generator: issues fetch addresses over valid/ready, applies
// redirects with priority over stalls and tags requests with a wrapping epoch.
// Ports:
//   clk, rst            : clock, asynchronous active-low reset
//   stall_i             : pipeline stall bus, bit STALL_PC stalls this stage
//   redirect_i/_pc_i    : single-cycle redirect strobe and target
//   req_valid_o/_pc_o   : fetch request and its address
//   req_epoch_o         : epoch tag of the current request
//   req_ready_i         : fetch stage accepts the request
//   epoch_o             : current epoch
//   misalign_o          : one-cycle pulse for a redirect target not STEP-aligned
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int unsigned STEP      = DEF_STEP,
  parameter int unsigned STALL_W   = 6,
  parameter int unsigned EPOCH_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  output logic               req_valid_o,
  output logic [ADDR_W-1:0]  req_pc_o,
  output logic [EPOCH_W-1:0] req_epoch_o,
  input  logic               req_ready_i,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic               misalign_o
);

  localparam logic [ADDR_W-1:0]  STEP_INC  = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0]  STEP_MASK = ADDR_W'(STEP - 1);
  localparam logic [EPOCH_W-1:0] EPOCH_ONE = EPOCH_W'(1);

  pc_state_e          state_q, state_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               misalign_q, misalign_d;

  logic stall_c;
  logic accept_c;
  logic stall_unused_c;

  assign stall_c        = stall_i[STALL_PC];
  assign accept_c       = valid_q & req_ready_i;
  // Only the PC-stage bit matters; fold the whole bus so no bit is left dangling.
  assign stall_unused_c = ^stall_i;

  // Next-state, next-PC and epoch selection.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    misalign_d = 1'b0;

    case (state_q)
      BOOT: begin
        // Redirects are ignored until the first request has been set up.
        pc_d    = RESET_VEC;
        valid_d = ~stall_c;
        state_d = stall_c ? HOLD : RUN;
      end
      default: begin
        if (redirect_i) begin
          // Replaces any pending request; a same-cycle accept used the old epoch.
          pc_d       = redirect_pc_i & ~STEP_MASK;
          valid_d    = 1'b1;
          epoch_d    = epoch_q + EPOCH_ONE;
          misalign_d = |(redirect_pc_i & STEP_MASK);
          state_d    = RUN;
        end else if (valid_q) begin
          // A pending request holds until accepted, even under stall.
          if (accept_c) begin
            pc_d    = pc_q + STEP_INC;
            valid_d = ~stall_c;
            state_d = stall_c ? HOLD : RUN;
          end
        end else begin
          // No request pending: pc_q already holds the next address.
          valid_d = ~stall_c;
          state_d = stall_c ? HOLD : RUN;
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      valid_q    <= 1'b0;
      pc_q       <= RESET_VEC;
      epoch_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      misalign_q <= misalign_d;
    end
  end

  assign req_valid_o = valid_q;
  assign req_pc_o    = pc_q;
  assign req_epoch_o = epoch_q;
  assign epoch_o     = epoch_q;
  assign misalign_o  = misalign_q;

endmodule : pc_gen

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch front end, the next generation of the single-issue PC register. It issues instruction-fetch addresses over a valid/ready handshake. It applies redirects (jump/branch/trap) with priority over stalls, and tags every request with a wrapping epoch so the fetch stage can drop responses from squashed paths. It also reports misaligned redirect targets.

## Interface
- `ADDR_W`, 32: PC width in bits.
- `RESET_VEC`, 0: first fetch address after reset.
- `STEP`, 4: bytes per sequential fetch; power of two, ≥1.
- `STALL_W`, 6: width of the pipeline stall bus; bit 0 is the PC stage stall.
- `EPOCH_W`, 2: epoch tag width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `stall_i` in STALL_W: stall bus; only bit 0 is used.
- `redirect_i` in 1: redirect request, single-cycle strobe.
- `redirect_pc_i` in ADDR_W: redirect target.
- `req_valid_o` out 1: fetch request valid.
- `req_pc_o` out ADDR_W: fetch address.
- `req_epoch_o` out EPOCH_W: epoch of the current request.
- `req_ready_i` in 1: fetch stage accepts the request.
- `epoch_o` out EPOCH_W: current epoch; compared downstream against response tags.
- `misalign_o` out 1: one-cycle pulse when a redirect target is not STEP-aligned.

## Operation
- States:
  - BOOT: held during reset and for the first cycle after it.
  - RUN: issuing requests.
  - HOLD: `stall_i[0]` is high and no request is pending.
- Reset values (asynchronous):
  - state = BOOT
  - `req_valid_o` = 0
  - `req_pc_o` = RESET_VEC
  - `req_epoch_o` = 0, `epoch_o` = 0
  - `misalign_o` = 0
- BOOT → RUN on the first edge after reset deasserts. The next cycle presents `req_valid_o` = 1 with `req_pc_o` = RESET_VEC. If `stall_i[0]` is high at that edge, the state goes BOOT → HOLD instead.
- Accept: `req_valid_o && req_ready_i`. After an accept, the next request carries `req_pc_o` + STEP, modulo 2^ADDR_W.
- Stability rule: while `req_valid_o` = 1 and the request is not accepted, `req_pc_o` and `req_epoch_o` hold and `req_valid_o` stays high. The stall does not withdraw a pending request. A redirect is the only event that may replace it.
- Stall (`stall_i[0]` = 1, no redirect):
  - On the accept edge, or whenever `req_valid_o` = 0, the state goes to HOLD with `req_valid_o` = 0.
  - `req_pc_o` presents the next address so the request resumes without a bubble.
  - HOLD → RUN when `stall_i[0]` falls; `req_valid_o` = 1 on the next cycle.
- Redirect (`redirect_i` = 1) has top priority in any state except BOOT, where it is ignored:
  - Next cycle: `req_pc_o` = `redirect_pc_i` with the low log2(STEP) bits cleared.
  - `req_valid_o` = 1 even if stalled; the redirect overrides the stall for that one request.
  - `epoch_o` and `req_epoch_o` both increment, wrapping at 2^EPOCH_W.
  - The state becomes RUN.
  - An unaccepted pending request is silently replaced.
  - An accept in the same cycle counts as accepted under the old epoch.
- Stall after a redirect: if `stall_i[0]` stays high, the redirected request is held until it is accepted. The state then goes to HOLD.
- `misalign_o` = 1 for exactly the cycle after a redirect whose target has any of the low log2(STEP) bits set. It is 0 when STEP = 1.
- Simultaneous redirect and stall: the redirect wins (see above).
- Simultaneous redirect and accept: both take effect; the new PC is the redirect target, not PC + STEP.
- Reset asserted mid-operation: all outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- Redirect in cycle N → `req_pc_o` = target and the new epoch in cycle N+1. One-cycle redirect latency.
- Accept in cycle N → `req_pc_o` + STEP in cycle N+1. Back-to-back accepts sustain one request per cycle.
- Stall release in cycle N (`stall_i[0]` low during N) → `req_valid_o` = 1 in N+1.
- Reset release → first valid request 2 cycles later (BOOT, then RUN).
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `pc_pkg`:
  - state enum {BOOT, RUN, HOLD}
  - `STALL_PC` = 0, the stall bus index
  - default `ADDR_W` and `STEP` constants shared with the fetch stage
- Single module, with no sub-module. The next-PC mux and epoch counter are small enough to stay inline.

## Test plan
- Reset release with `req_ready_i` = 1 constantly, RESET_VEC = 0x100 → `req_pc_o` 0x100, 0x104, 0x108 on consecutive cycles; `req_epoch_o` = 0.
- `req_ready_i` low for 3 cycles at PC 0x108 while `stall_i[0]` rises → 0x108 held valid; after the accept, `req_valid_o` = 0 until the stall falls, then 0x10C.
- Redirect to 0x2000 while stalled with an unaccepted request at 0x10C → next cycle 0x2000 is valid, epoch 0→1, and 0x10C is never accepted.
- Redirect to 0x2002 with STEP = 4 → `req_pc_o` = 0x2000 and a one-cycle `misalign_o` pulse. Four further redirects → epoch wraps 3→0.
- Sequential fetch from 0xFFFF_FFFC with ADDR_W = 32 → next PC 0x0000_0000.
- Reset asserted asynchronously mid-stream → `req_valid_o` = 0 and `req_pc_o` = RESET_VEC before the next edge; a redirect during BOOT is ignored.
